updn_cnt: RTL and testbench

Parametrised synchronous up/down counter, the next-generation replacement for the fixed 16-bit free-running counter. Adds configurable width, configurable terminal value (modulo-N), count enable, direction control, parallel load, and wrap or saturate behaviour. It also provides status flags: full, empty, a one-cycle terminal-count pulse and a sticky overflow. It is used as a general event/timer counter in datapath and control blocks.

---
 rtl/updn_cnt_pkg.sv | 12 +
 rtl/updn_cnt_if.sv | 29 ++
 rtl/updn_cnt.sv | 84 ++++++++
 tb/tb_updn_cnt.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/updn_cnt_pkg.sv
// Shared constants for the up/down counter family.
//   CNT_UP / CNT_DN     : encodings of the direction input
//   MODE_WRAP / MODE_SAT: encodings of the SAT parameter
package cnt_pkg;

  localparam logic CNT_UP    = 1'b1;
  localparam logic CNT_DN    = 1'b0;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

endpackage : cnt_pkg

// File: rtl/updn_cnt_if.sv
// Control/status bundle of the up/down counter.
//   master: drives en, up, ld, ld_val, clr_ovf; observes Q, full, empty, tc, ovf
//   slave : the counter itself, the reverse direction
interface updn_cnt_if #(
  parameter int WIDTH = 16
);

  logic             en;
  logic             up;
  logic             ld;
  logic [WIDTH-1:0] ld_val;
  logic             clr_ovf;
  logic [WIDTH-1:0] Q;
  logic             full;
  logic             empty;
  logic             tc;
  logic             ovf;

  modport master (
    output en, up, ld, ld_val, clr_ovf,
    input  Q, full, empty, tc, ovf
  );

  modport slave (
    input  en, up, ld, ld_val, clr_ovf,
    output Q, full, empty, tc, ovf
  );

endinterface : updn_cnt_if

// File: rtl/updn_cnt.sv
// Parametrised synchronous up/down counter with modulo terminal value,
// parallel load, wrap/saturate mode and full/empty/tc/ovf status.
//   CLK  : clock, all state changes on the rising edge
//   CLRN : synchronous active-low reset
//   bus  : slave side of updn_cnt_if (en, up, ld, ld_val, clr_ovf in;
//          Q, full, empty, tc, ovf out)
module updn_cnt
  import cnt_pkg::*;
#(
  parameter int             WIDTH = 16,
  parameter logic [WIDTH-1:0] MAX = {WIDTH{1'b1}},
  parameter logic           SAT   = MODE_WRAP
) (
  input  logic        CLK,
  input  logic        CLRN,
  updn_cnt_if.slave   bus
);

  localparam logic [WIDTH:0] MAX_EXT = {1'b0, MAX};
  localparam logic [WIDTH:0] ONE_EXT = {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             tc_q;
  logic             tc_d;
  logic             ovf_q;
  logic             ovf_d;
  logic [WIDTH:0]   nxt_up_s;
  logic [WIDTH:0]   nxt_dn_s;
  logic             lim_s;

  // Next-value and limit detection; the extra MSB flags overrun past MAX
  // (up) or borrow below zero (down) even when MAX is all ones.
  always_comb begin
    nxt_up_s = {1'b0, q_q} + ONE_EXT;
    nxt_dn_s = {1'b0, q_q} - ONE_EXT;
    lim_s    = 1'b0;
    q_d      = q_q;
    if (bus.ld) begin
      q_d = (bus.ld_val > MAX) ? MAX : bus.ld_val;
    end else if (bus.en) begin
      if (bus.up == CNT_UP) begin
        if (nxt_up_s > MAX_EXT) begin
          lim_s = 1'b1;
          q_d   = (SAT == MODE_SAT) ? MAX : {WIDTH{1'b0}};
        end else begin
          q_d = nxt_up_s[WIDTH-1:0];
        end
      end else begin
        if (nxt_dn_s[WIDTH]) begin
          lim_s = 1'b1;
          q_d   = (SAT == MODE_SAT) ? {WIDTH{1'b0}} : MAX;
        end else begin
          q_d = nxt_dn_s[WIDTH-1:0];
        end
      end
    end else begin
      q_d = q_q;
    end
    tc_d  = lim_s;
    // A limit event wins over a simultaneous clear request.
    ovf_d = lim_s | (ovf_q & ~bus.clr_ovf);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!CLRN) begin
      q_q   <= {WIDTH{1'b0}};
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  assign bus.Q     = q_q;
  assign bus.tc    = tc_q;
  assign bus.ovf   = ovf_q;
  assign bus.full  = (q_q == MAX);
  assign bus.empty = (q_q == {WIDTH{1'b0}});

endmodule : updn_cnt

// File: tb/tb_updn_cnt.sv
// Directed bench for updn_cnt: a default 16-bit wrapping counter, a
// modulo-10 wrapping counter and a modulo-10 saturating counter share one
// clock and reset.
module tb_updn_cnt;

  logic CLK;
  logic CLRN;
  int   n_cmp;
  int   n_bad;

  updn_cnt_if #(.WIDTH(16)) ifd ();
  updn_cnt_if #(.WIDTH(4))  ifm ();
  updn_cnt_if #(.WIDTH(4))  ifs ();

  updn_cnt #(.WIDTH(16)) u_def (.CLK(CLK), .CLRN(CLRN), .bus(ifd));
  updn_cnt #(.WIDTH(4), .MAX(4'd9), .SAT(1'b0)) u_mod (.CLK(CLK), .CLRN(CLRN), .bus(ifm));
  updn_cnt #(.WIDTH(4), .MAX(4'd9), .SAT(1'b1)) u_sat (.CLK(CLK), .CLRN(CLRN), .bus(ifs));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    CLRN = 1'b0;
    ifd.en = 1'b0; ifd.up = 1'b0; ifd.ld = 1'b0; ifd.ld_val = 16'h0000; ifd.clr_ovf = 1'b0;
    ifm.en = 1'b0; ifm.up = 1'b0; ifm.ld = 1'b0; ifm.ld_val = 4'h0;     ifm.clr_ovf = 1'b0;
    ifs.en = 1'b0; ifs.up = 1'b0; ifs.ld = 1'b0; ifs.ld_val = 4'h0;     ifs.clr_ovf = 1'b0;

    // Reset
    step(1);
    chk("rst_q",     ifd.Q,     32'h0);
    chk("rst_empty", ifd.empty, 32'h1);
    chk("rst_full",  ifd.full,  32'h0);
    chk("rst_tc",    ifd.tc,    32'h0);
    chk("rst_ovf",   ifd.ovf,   32'h0);

    // Count up 5 from reset release
    CLRN = 1'b1; ifd.en = 1'b1; ifd.up = 1'b1;
    step(5);
    chk("cnt5_q", ifd.Q, 32'h5);
    chk("cnt5_empty", ifd.empty, 32'h0);

    // Wrap at 0xFFFF
    ifd.ld = 1'b1; ifd.ld_val = 16'hFFFD;
    step(1);
    chk("ld_fffd_q", ifd.Q, 32'hFFFD);
    chk("ld_fffd_tc", ifd.tc, 32'h0);
    ifd.ld = 1'b0;
    step(2);
    chk("top_q",    ifd.Q,    32'hFFFF);
    chk("top_full", ifd.full, 32'h1);
    chk("top_tc",   ifd.tc,   32'h0);
    step(1);
    chk("wrap_q",     ifd.Q,     32'h0);
    chk("wrap_tc",    ifd.tc,    32'h1);
    chk("wrap_ovf",   ifd.ovf,   32'h1);
    chk("wrap_empty", ifd.empty, 32'h1);
    step(1);
    chk("post_wrap_q",   ifd.Q,   32'h1);
    chk("post_wrap_tc",  ifd.tc,  32'h0);
    chk("post_wrap_ovf", ifd.ovf, 32'h1);
    ifd.clr_ovf = 1'b1;
    step(1);
    chk("clr_ovf", ifd.ovf, 32'h0);
    chk("clr_q",   ifd.Q,   32'h2);
    ifd.clr_ovf = 1'b0;

    // Load beats enable
    ifd.ld = 1'b1; ifd.ld_val = 16'h1234;
    step(1);
    chk("ld_pri_q", ifd.Q, 32'h1234);

    // Limit event beats clr_ovf
    ifd.ld_val = 16'hFFFF;
    step(1);
    ifd.ld = 1'b0; ifd.clr_ovf = 1'b1;
    step(1);
    chk("setclr_q",   ifd.Q,   32'h0);
    chk("setclr_tc",  ifd.tc,  32'h1);
    chk("setclr_ovf", ifd.ovf, 32'h1);
    ifd.clr_ovf = 1'b0;

    // Hold with en=0
    ifd.en = 1'b0;
    step(2);
    chk("hold_q",   ifd.Q,   32'h0);
    chk("hold_tc",  ifd.tc,  32'h0);
    chk("hold_ovf", ifd.ovf, 32'h1);

    // Mid-run reset is synchronous
    ifd.ld = 1'b1; ifd.ld_val = 16'h0100;
    step(1);
    chk("ld100_q", ifd.Q, 32'h100);
    ifd.ld = 1'b0; ifd.en = 1'b1;
    step(1);
    chk("cnt101_q", ifd.Q, 32'h101);
    CLRN = 1'b0;
    #3;
    chk("no_async_q", ifd.Q, 32'h101);
    step(1);
    chk("mrst_q",     ifd.Q,     32'h0);
    chk("mrst_ovf",   ifd.ovf,   32'h0);
    chk("mrst_tc",    ifd.tc,    32'h0);
    chk("mrst_empty", ifd.empty, 32'h1);
    CLRN = 1'b1; ifd.en = 1'b0;

    // Modulo-10 wrap, up and down
    ifm.ld = 1'b1; ifm.ld_val = 4'd9;
    step(1);
    chk("mod_ld_q",    ifm.Q,    32'h9);
    chk("mod_ld_full", ifm.full, 32'h1);
    ifm.ld = 1'b0; ifm.en = 1'b1; ifm.up = 1'b1;
    step(1);
    chk("mod_upwrap_q",  ifm.Q,  32'h0);
    chk("mod_upwrap_tc", ifm.tc, 32'h1);
    ifm.up = 1'b0;
    step(1);
    chk("mod_dnwrap_q",  ifm.Q,  32'h9);
    chk("mod_dnwrap_tc", ifm.tc, 32'h1);
    step(1);
    chk("mod_dn8_q",  ifm.Q,  32'h8);
    chk("mod_dn8_tc", ifm.tc, 32'h0);
    ifm.ld = 1'b1; ifm.ld_val = 4'd15;
    step(1);
    chk("mod_clamp_q",  ifm.Q,  32'h9);
    chk("mod_clamp_tc", ifm.tc, 32'h0);
    ifm.ld = 1'b0; ifm.en = 1'b0;

    // Saturating modulo-10
    ifs.ld = 1'b1; ifs.ld_val = 4'd12;
    step(1);
    chk("sat_clamp_q",   ifs.Q,   32'h9);
    chk("sat_clamp_tc",  ifs.tc,  32'h0);
    chk("sat_clamp_ovf", ifs.ovf, 32'h0);
    ifs.ld = 1'b0; ifs.en = 1'b1; ifs.up = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk($sformatf("sat_up_q%0d", i),  ifs.Q,  32'h9);
      chk($sformatf("sat_up_tc%0d", i), ifs.tc, 32'h1);
    end
    chk("sat_up_ovf", ifs.ovf, 32'h1);
    ifs.up = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      step(1);
      chk($sformatf("sat_dn_q%0d", i),  ifs.Q,  32'(9 - i));
      chk($sformatf("sat_dn_tc%0d", i), ifs.tc, 32'h0);
    end
    step(1);
    chk("sat_dn_q10",    ifs.Q,     32'h0);
    chk("sat_dn_tc10",   ifs.tc,    32'h1);
    chk("sat_dn_empty",  ifs.empty, 32'h1);
    ifs.en = 1'b0;
    step(1);
    chk("sat_idle_tc", ifs.tc, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_updn_cnt
